// File: rtl/shift_register_universal_if.sv
// Handshake/data bundle for shift_register_universal.
// SHIFT_REG_ROTATE_EN adds the rot control line.
interface shift_register_universal_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH);

  logic             en;
  logic [1:0]       mode;
  logic             si_r;
  logic             si_l;
  logic [WIDTH-1:0] pin;
  logic [WIDTH-1:0] pout;
  logic             so_r;
  logic             so_l;
  logic [CW-1:0]    shift_cnt;
  logic             frame_done;
`ifdef SHIFT_REG_ROTATE_EN
  logic             rot;

  modport master (
    output en, mode, si_r, si_l, pin, rot,
    input  pout, so_r, so_l, shift_cnt, frame_done
  );
  modport slave (
    input  en, mode, si_r, si_l, pin, rot,
    output pout, so_r, so_l, shift_cnt, frame_done
  );
`else
  modport master (
    output en, mode, si_r, si_l, pin,
    input  pout, so_r, so_l, shift_cnt, frame_done
  );
  modport slave (
    input  en, mode, si_r, si_l, pin,
    output pout, so_r, so_l, shift_cnt, frame_done
  );
`endif
endinterface

// File: rtl/shift_register_universal.sv
// WIDTH-bit hold/shift/load register with a frame counter.
// Optional macro SHIFT_REG_ROTATE_EN turns shifts into rotates.
module shift_register_universal #(
  parameter int WIDTH = 8
) (
  input logic                    clk,
  input logic                    rst,
  shift_register_universal_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             in_r, in_l;
  logic             shift;

  // serial inputs, replaced by the wrapped-around bit when rotating
  always_comb begin
`ifdef SHIFT_REG_ROTATE_EN
    in_r = bus.rot ? q_q[0] : bus.si_r;
    in_l = bus.rot ? q_q[WIDTH-1] : bus.si_l;
`else
    in_r = bus.si_r;
    in_l = bus.si_l;
`endif
  end

  // next-state: register op, shared shift counter, frame pulse
  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    shift  = 1'b0;
    if (bus.en) begin
      unique case (bus.mode)
        2'b01: begin
          q_d   = {in_r, q_q[WIDTH-1:1]};
          shift = 1'b1;
        end
        2'b10: begin
          q_d   = {q_q[WIDTH-2:0], in_l};
          shift = 1'b1;
        end
        2'b11: begin
          q_d   = bus.pin;
          cnt_d = '0;
        end
        default: ;
      endcase
      if (shift) begin
        if (cnt_q == LAST) begin
          cnt_d  = '0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign bus.pout       = q_q;
  assign bus.so_r       = q_q[0];
  assign bus.so_l       = q_q[WIDTH-1];
  assign bus.shift_cnt  = cnt_q;
  assign bus.frame_done = done_q;
endmodule

// File: tb/tb_shift_register_universal.sv
// Randomised bench for shift_register_universal against an
// arithmetic reference model (rotate paths under SHIFT_REG_ROTATE_EN).
module tb_shift_register_universal;
  localparam int W = 8;
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  int mq = 0;
  int mcnt = 0;
  int mdone = 0;

  shift_register_universal_if #(.WIDTH(W)) bus ();

  shift_register_universal #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("pout", 32'(bus.pout), mq);
    chk("so_r", 32'(bus.so_r), mq & 1);
    chk("so_l", 32'(bus.so_l), (mq >> (W - 1)) & 1);
    chk("cnt", 32'(bus.shift_cnt), mcnt);
    chk("done", 32'(bus.frame_done), mdone);
  endtask

  // drive one cycle, advance the model, check after the edge
  task automatic op(input bit e, input bit [1:0] m, input bit sr,
                    input bit sl, input int p, input bit r);
    int in_bit;
    bus.en   = e;
    bus.mode = m;
    bus.si_r = sr;
    bus.si_l = sl;
    bus.pin  = W'(p);
`ifdef SHIFT_REG_ROTATE_EN
    bus.rot  = r;
`else
    r = 1'b0;
`endif
    if (!e || m == 2'd0) begin
      mdone = 0;
    end else if (m == 2'd3) begin
      mq = p & MASK;
      mcnt = 0;
      mdone = 0;
    end else begin
      if (m == 2'd1) begin
        in_bit = r ? (mq & 1) : int'(sr);
        mq = (mq >> 1) | (in_bit << (W - 1));
      end else begin
        in_bit = r ? ((mq >> (W - 1)) & 1) : int'(sl);
        mq = ((mq << 1) | in_bit) & MASK;
      end
      mcnt++;
      if (mcnt == W) begin
        mcnt = 0;
        mdone = 1;
      end else begin
        mdone = 0;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    bit [7:0] sipo;
    int r;
    sipo = 8'b1011_0010;
    bus.en = 1'b0;
    bus.mode = 2'd0;
    bus.si_r = 1'b0;
    bus.si_l = 1'b0;
    bus.pin = '0;
`ifdef SHIFT_REG_ROTATE_EN
    bus.rot = 1'b0;
`endif
    #12;
    check_all();
    rst = 1'b1;

    // async reset mid-cycle
    op(1, 3, 0, 0, 'hFF, 0);
    repeat (3) op(1, 1, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    mq = 0; mcnt = 0; mdone = 0;
    check_all();
    #2;
    rst = 1'b1;
    op(1, 1, 1, 0, 0, 0);
    chk("rel_pout", 32'(bus.pout), 32'h80);

    // PISO
    op(1, 3, 0, 0, 'hA5, 0);
    for (int i = 0; i < W; i++) op(1, 1, 0, 0, 0, 0);
    chk("piso_pout", 32'(bus.pout), 32'h0);
    chk("piso_done", 32'(bus.frame_done), 32'h1);
    op(1, 0, 0, 0, 0, 0);

    // SIPO then a second frame
    op(1, 3, 0, 0, 0, 0);
    for (int i = W - 1; i >= 0; i--) op(1, 2, 0, sipo[i], 0, 0);
    chk("sipo_pout", 32'(bus.pout), 32'hB2);
    for (int i = 0; i < W; i++) op(1, 2, 0, 1, 0, 0);
    chk("sipo_done2", 32'(bus.frame_done), 32'h1);

    // enable / hold
    op(1, 3, 0, 0, 'h3C, 0);
    repeat (3) op(0, 1, 1, 1, 0, 0);
    repeat (2) op(1, 0, 1, 1, 0, 0);
    chk("hold_pout", 32'(bus.pout), 32'h3C);

    // mid-frame load
    repeat (3) op(1, 1, 1, 0, 0, 0);
    op(1, 3, 0, 0, 'h5A, 0);
    chk("ld_cnt", 32'(bus.shift_cnt), 32'h0);
    for (int i = 0; i < W; i++) op(1, 1, 0, 0, 0, 0);

`ifdef SHIFT_REG_ROTATE_EN
    op(1, 3, 0, 0, 'h81, 1);
    op(1, 1, 0, 0, 0, 1);
    chk("rot_r", 32'(bus.pout), 32'hC0);
    op(1, 3, 0, 0, 'h81, 1);
    op(1, 2, 0, 0, 0, 1);
    chk("rot_l", 32'(bus.pout), 32'h03);
    op(1, 3, 0, 0, 'hA5, 1);
    for (int i = 0; i < W; i++) op(1, 1, 0, 0, 0, 1);
    chk("rot_full", 32'(bus.pout), 32'hA5);
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      op(($urandom_range(0, 9) != 0),
         (r == 0) ? 2'd0 : (r == 1) ? 2'd3 : (r < 6) ? 2'd1 : 2'd2,
         1'($urandom), 1'($urandom), int'($urandom & MASK),
         1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shift_register_universal.md
Name: shift_register_universal

Overview:
Parametrised universal shift register, successor to the fixed 8-bit SISO block. One WIDTH-bit register supports hold, shift right, shift left and parallel load, so one block covers SISO, SIPO, PISO and PIPO. A shift counter flags completion of each WIDTH-bit serial frame. Used at serial/parallel boundaries in the sequential_logic library.

Parameters:
WIDTH, 8, register width in bits; legal range is 2 or more.
CW, $clog2(WIDTH), shift counter width; derived, not overridden.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous active-low reset; rst=0 clears all state immediately.
en  input  1  clock enable; en=0 freezes all state.
mode  input  2  operation: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
si_r  input  1  serial input for shift right; enters at bit WIDTH-1.
si_l  input  1  serial input for shift left; enters at bit 0.
pin  input  WIDTH  parallel load data.
pout  output  WIDTH  register contents q.
so_r  output  1  serial output for shift right; equals q[0].
so_l  output  1  serial output for shift left; equals q[WIDTH-1].
shift_cnt  output  CW  number of shifts since the last frame boundary, load or reset.
frame_done  output  1  registered one-cycle pulse after the WIDTH-th shift of a frame.

Behaviour:
- Reset (rst=0, asynchronous, no clock edge needed): q=0, shift_cnt=0, frame_done=0, so pout=0, so_r=0, so_l=0. Release is synchronous to the next clk edge; the first update happens on the first rising edge with rst=1.
- en=0: q and shift_cnt hold; frame_done <= 0.
- en=1 effects, each on one clk edge, with pout updating the same edge:
  - mode 00: q holds, shift_cnt holds, frame_done <= 0.
  - mode 01: q <= {si_r, q[WIDTH-1:1]}.
  - mode 10: q <= {q[WIDTH-2:0], si_l}.
  - mode 11: q <= pin, shift_cnt <= 0, frame_done <= 0. A load aborts any partial frame.
- Shift counting (modes 01 and 10):
  - If shift_cnt == WIDTH-1: shift_cnt <= 0 and frame_done <= 1. frame_done is high during the cycle after the WIDTH-th shift edge.
  - Otherwise: shift_cnt <= shift_cnt+1 and frame_done <= 0.
  - Right and left shifts share one counter; a change of direction mid-frame does not reset it.
- so_r and so_l are combinational from q, with no extra latency; SIPO/PISO latency is one edge per bit.
- Back-to-back frames: continuous shifting gives a frame_done pulse every WIDTH cycles with no dead cycle.
- Simultaneous events: rst dominates everything. Among the mode values only one applies per cycle, since mode is an encoded field.
- Non-power-of-two WIDTH (e.g. 6): the counter wraps at WIDTH-1, never at 2^CW-1.

Optional Feature:
Macro SHIFT_REG_ROTATE_EN.
- Defined: adds input port rot (1 bit). When rot=1:
  - mode 01 performs q <= {q[0], q[WIDTH-1:1]} and ignores si_r.
  - mode 10 performs q <= {q[WIDTH-2:0], q[WIDTH-1]} and ignores si_l.
  - Rotates count as shifts for shift_cnt and frame_done.
  - rot has no effect in modes 00 and 11.
- Not defined: no rot port; shifts always take si_r/si_l; behaviour exactly as above.

Test Plan:
1. Async reset: load 0xFF, shift 3 times, then assert rst=0 between clock edges -> pout=0x00, so_r=0, so_l=0, shift_cnt=0, frame_done=0 before the next edge. On release, the first enabled shift updates q on the first edge.
2. PISO: load pin=0xA5 (mode 11), then 8 right shifts with si_r=0 -> so_r sequence before each edge is 1,0,1,0,0,1,0,1. After the 8th edge pout=0x00, and frame_done=1 for exactly one cycle, then 0.
3. SIPO: 8 left shifts with si_l sequence 1,0,1,1,0,0,1,0 -> pout=0xB2 and a frame_done pulse. Continuing to shift gives the next pulse exactly 8 cycles later.
4. Enable/hold: after load 0x3C, en=0 with mode=01 for 3 cycles, then en=1 with mode=00 for 2 cycles -> pout stays 0x3C, shift_cnt stays 0, frame_done stays 0.
5. Mid-frame load: 3 right shifts (shift_cnt=3), then load 0x5A -> shift_cnt=0, no frame_done. frame_done pulses only after 8 further shifts.
6. Rotate (SHIFT_REG_ROTATE_EN defined): load 0x81 with rot=1. One right shift -> 0xC0. Reload 0x81, one left shift -> 0x03. 8 right rotates of 0xA5 -> pout=0xA5 and a frame_done pulse.
